// File: rtl/trigger_manager_multi_if.sv
// Readout-FIFO record channel of the fill sequencer.
// Handshake: the master raises fifo_valid with fifo_data and holds both stable
// until a cycle in which fifo_ready is also high; that edge transfers the record.
interface trigger_manager_multi_if #(
  parameter int DATA_W = 30
) ();
  logic              fifo_valid;
  logic              fifo_ready;
  logic [DATA_W-1:0] fifo_data;

  modport master (output fifo_valid, output fifo_data, input fifo_ready);
  modport slave  (input fifo_valid, input fifo_data, output fifo_ready);
endinterface

// File: rtl/trigger_manager_multi.sv
// Fill sequencer: queues accepted triggers with their fill numbers, runs one
// fill at a time across the enabled channels (bounded by a timeout) and hands
// a {timeout, done_seen, fill_num} record to the readout FIFO.
module trigger_manager_multi #(
  parameter int NUM_CHAN       = 5,
  parameter int FILL_NUM_W     = 24,
  parameter int TRIG_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          trigger,
  input  logic                          cm_busy,
  input  logic [NUM_CHAN-1:0]           chan_enable,
  input  logic [NUM_CHAN-1:0]           done,
  output logic [NUM_CHAN-1:0]           go,
  trigger_manager_multi_if.master       fifo,
  output logic [FILL_NUM_W-1:0]         fill_num,
  output logic [$clog2(TRIG_DEPTH):0]   trig_pending,
  output logic [15:0]                   trig_dropped,
  output logic [1:0]                    o_dbg_state
);

  localparam int PTR_W = $clog2(TRIG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int REC_W = 1 + NUM_CHAN + FILL_NUM_W;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [FILL_NUM_W-1:0] r_queue [TRIG_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [FILL_NUM_W-1:0] r_fill_num;
  logic [15:0]           r_dropped;

  logic [FILL_NUM_W-1:0] r_cur_fill;
  logic [NUM_CHAN-1:0]   r_en_q;
  logic [NUM_CHAN-1:0]   r_done_seen;
  logic [TMR_W-1:0]      r_timer;
  logic [NUM_CHAN-1:0]   r_go;
  logic [REC_W-1:0]      r_rec;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_finish;
  logic                  w_timeout;
  logic [NUM_CHAN-1:0]   w_seen_nxt;
  logic                  w_all_done;
  logic                  w_timer_last;
  logic [FILL_NUM_W-1:0] w_fill_inc;

  assign w_full       = (r_count == CNT_W'(TRIG_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_accept     = trigger & ~cm_busy;
  assign w_push       = w_accept & ~w_full;
  assign w_drop       = w_accept & w_full;
  assign w_fill_inc   = r_fill_num + FILL_NUM_W'(1);
  // A done seen in the completing cycle counts, so the final mask includes it.
  assign w_seen_nxt   = r_done_seen | (done & r_en_q);
  // Disabled channels count as complete, so an empty mask finishes at once.
  assign w_all_done   = &(w_seen_nxt | ~r_en_q);
  assign w_timer_last = (r_timer == TMR_LAST);

  assign go              = r_go;
  assign fifo.fifo_valid = (r_state == S_STORE);
  assign fifo.fifo_data  = r_rec;
  assign fill_num        = r_fill_num;
  assign trig_pending    = r_count;
  assign trig_dropped    = r_dropped;
  assign o_dbg_state     = r_state;

  // Next state, queue pop and fill completion; completion beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (w_all_done) begin
          w_finish    = 1'b1;
          w_state_nxt = S_STORE;
        end else if (w_timer_last) begin
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_STORE;
        end
      end
      S_STORE: begin
        if (fifo.fifo_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Queue storage; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_queue[r_wr_ptr] <= w_fill_inc;
  end

  // Queue pointers and occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Fill numbering and saturating count of triggers lost to a full queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_num <= '0;
      r_dropped  <= '0;
    end else begin
      if (w_push) r_fill_num <= w_fill_inc;
      if (w_drop && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
    end
  end

  // Per-fill context: mask and go latched at start, record captured at finish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_fill  <= '0;
      r_en_q      <= '0;
      r_done_seen <= '0;
      r_timer     <= '0;
      r_go        <= '0;
      r_rec       <= '0;
    end else if (w_pop) begin
      r_cur_fill  <= r_queue[r_rd_ptr];
      r_en_q      <= chan_enable;
      r_done_seen <= '0;
      r_timer     <= '0;
      r_go        <= chan_enable;
    end else if (r_state == S_FILL) begin
      r_done_seen <= w_seen_nxt;
      r_timer     <= r_timer + TMR_W'(1);
      if (w_finish) begin
        r_go  <= '0;
        r_rec <= {w_timeout, w_seen_nxt, r_cur_fill};
      end
    end
  end

endmodule

// File: tb/tb_trigger_manager_multi.sv
// Bench for trigger_manager_multi: directed scenarios with literal checks plus
// a randomized run, all compared each cycle against a queue-based model.
`timescale 1ns/1ps
module tb_trigger_manager_multi;
  localparam int NC  = 5;
  localparam int FW  = 24;
  localparam int TD  = 4;
  localparam int TMO = 16;
  localparam int RW  = 1 + NC + FW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          trigger = 1'b0;
  logic          cm_busy = 1'b0;
  logic [NC-1:0] chan_enable = '0;
  logic [NC-1:0] done = '0;
  logic [NC-1:0] go;
  logic [FW-1:0] fill_num;
  logic [2:0]    trig_pending;
  logic [15:0]   trig_dropped;
  logic [1:0]    dbg_state;

  trigger_manager_multi_if #(.DATA_W(RW)) fifo_if ();

  trigger_manager_multi #(
    .NUM_CHAN(NC), .FILL_NUM_W(FW), .TRIG_DEPTH(TD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .cm_busy(cm_busy),
    .chan_enable(chan_enable), .done(done), .go(go), .fifo(fifo_if.master),
    .fill_num(fill_num), .trig_pending(trig_pending),
    .trig_dropped(trig_dropped), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / checker ----------------
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic [RW-1:0] rec_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired", name);
  endtask

  // ---------------- reference model ----------------
  // Pending fill numbers, plus a description of the fill being run.
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] m_fill_num = '0;
  logic [15:0]   m_dropped = '0;
  bit            m_in_fill = 1'b0;
  bit            m_store = 1'b0;
  bit            m_to = 1'b0;
  int            m_cycles = 0;
  logic [NC-1:0] m_en = '0;
  logic [NC-1:0] m_seen = '0;
  logic [FW-1:0] m_cur = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_fill_num = '0; m_dropped = '0;
      m_in_fill = 0; m_store = 0; m_to = 0; m_cycles = 0;
      m_en = '0; m_seen = '0; m_cur = '0;
    end else begin
      int qn;
      qn = exp_q.size();
      if (m_in_fill) begin
        m_seen = m_seen | (done & m_en);
        m_cycles++;
        if (m_seen == m_en) begin
          m_in_fill = 0; m_store = 1; m_to = 0;
        end else if (m_cycles == TMO) begin
          m_in_fill = 0; m_store = 1; m_to = 1;
        end
      end else if (m_store) begin
        if (fifo_if.fifo_ready) m_store = 0;
      end else if (qn > 0) begin
        m_cur = exp_q.pop_front();
        m_en = chan_enable; m_seen = '0; m_cycles = 0; m_in_fill = 1;
      end
      if (trigger && !cm_busy) begin
        if (qn == TD) begin
          if (m_dropped != 16'hFFFF) m_dropped = m_dropped + 16'd1;
        end else begin
          m_fill_num = m_fill_num + 1'b1;
          exp_q.push_back(m_fill_num);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("go", go, m_in_fill ? m_en : '0);
      check("fifo_valid", fifo_if.fifo_valid, m_store);
      if (m_store) check("fifo_data", fifo_if.fifo_data, {m_to, m_seen, m_cur});
      check("fill_num", fill_num, m_fill_num);
      check("trig_pending", trig_pending, exp_q.size());
      check("trig_dropped", trig_dropped, m_dropped);
      if (fifo_if.fifo_valid && fifo_if.fifo_ready) rec_q.push_back(fifo_if.fifo_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
  endtask

  task automatic wait_rec(input string name, input logic [RW-1:0] exp);
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (rec_q.size() > 0) begin
        got = 1;
        break;
      end
      cyc();
    end
    if (got) check(name, rec_q.pop_front(), exp);
    else     fail_now(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    fifo_if.fifo_ready = 1'b1;
    repeat (3) cyc();
    // reset state
    check("rst_go", go, 0);
    check("rst_valid", fifo_if.fifo_valid, 0);
    check("rst_data", fifo_if.fifo_data, 0);
    check("rst_fill_num", fill_num, 0);
    check("rst_pending", trig_pending, 0);
    check("rst_dropped", trig_dropped, 0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // 1: full mask, all channels done together
    chan_enable = 5'h1F;
    pulse_trigger();
    check("t1_pending", trig_pending, 1);
    check("t1_go_early", go, 0);
    cyc();
    check("t1_go", go, 5'h1F);
    check("t1_pending_after_pop", trig_pending, 0);
    cyc(); cyc();
    done = 5'h1F;
    cyc();
    done = '0;
    check("t1_valid", fifo_if.fifo_valid, 1);
    wait_rec("t1_rec", {1'b0, 5'h1F, 24'd1});
    check("t1_fill_num", fill_num, 1);

    // 2: partial mask, done on a disabled channel ignored, mask change ignored
    chan_enable = 5'b00101;
    pulse_trigger();
    cyc();
    check("t2_go", go, 5'b00101);
    chan_enable = 5'h1F;
    done = 5'b00011;
    cyc();
    done = '0;
    cyc();
    done = 5'b00100;
    cyc();
    done = '0;
    wait_rec("t2_rec", {1'b0, 5'b00101, 24'd2});

    // 3: channel 3 never finishes -> timeout after TMO fill cycles
    chan_enable = 5'h1F;
    pulse_trigger();
    cyc();
    done = 5'b10111;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (go == '0) break;
      cnt++;
      cyc();
      done = '0;
    end
    check("t3_fill_cycles", cnt, TMO);
    wait_rec("t3_rec", {1'b1, 5'b10111, 24'd3});

    // 4: back-pressure fills the queue, overflow triggers dropped
    fifo_if.fifo_ready = 1'b0;
    done = 5'h1F;
    pulse_trigger();
    cyc(); cyc();
    check("t4_valid", fifo_if.fifo_valid, 1);
    trigger = 1'b1;
    repeat (6) cyc();
    trigger = 1'b0;
    check("t4_pending", trig_pending, 4);
    check("t4_dropped", trig_dropped, 2);
    check("t4_fill_num", fill_num, 8);
    fifo_if.fifo_ready = 1'b1;
    for (int n = 4; n <= 8; n++) wait_rec("t4_rec", {1'b0, 5'h1F, FW'(n)});
    done = '0;
    cyc();

    // 5: fill number wraps; busy triggers change nothing
    force dut.r_fill_num = 24'hFFFFFF;
    m_fill_num = 24'hFFFFFF;
    cyc();
    release dut.r_fill_num;
    cyc();
    check("t5_preload", fill_num, 24'hFFFFFF);
    done = 5'h1F;
    pulse_trigger();
    check("t5_wrap", fill_num, 0);
    wait_rec("t5_rec", {1'b0, 5'h1F, 24'd0});
    done = '0;
    cm_busy = 1'b1;
    trigger = 1'b1;
    repeat (3) cyc();
    trigger = 1'b0;
    cm_busy = 1'b0;
    check("t5_busy_fill_num", fill_num, 0);
    check("t5_busy_pending", trig_pending, 0);
    check("t5_busy_dropped", trig_dropped, 2);

    // 6: reset in the middle of a fill
    pulse_trigger();
    cyc();
    trigger = 1'b1;
    repeat (2) cyc();
    trigger = 1'b0;
    check("t6_go_before", go, 5'h1F);
    #2 reset_n = 1'b0;
    #1;
    check("t6_go", go, 0);
    check("t6_valid", fifo_if.fifo_valid, 0);
    check("t6_data", fifo_if.fifo_data, 0);
    check("t6_pending", trig_pending, 0);
    check("t6_fill_num", fill_num, 0);
    check("t6_dropped", trig_dropped, 0);
    cyc();
    reset_n = 1'b1;
    repeat (25) cyc();
    check("t6_no_record", rec_q.size(), 0);
    check("t6_go_idle", go, 0);

    // randomized traffic, one reset part-way through
    for (int i = 0; i < 1500; i++) begin
      trigger = ($urandom_range(0, 3) == 0);
      cm_busy = ($urandom_range(0, 7) == 0);
      chan_enable = ($urandom_range(0, 9) == 0) ? '0 : NC'($urandom);
      done = NC'($urandom) & NC'($urandom);
      fifo_if.fifo_ready = ($urandom_range(0, 3) != 0);
      if (i == 750) reset_n = 1'b0;
      if (i == 752) reset_n = 1'b1;
      cyc();
    end
    trigger = 1'b0;
    cm_busy = 1'b0;
    done = 5'h1F;
    fifo_if.fifo_ready = 1'b1;
    repeat (40) cyc();
    check("drain_pending", trig_pending, 0);
    check("drain_valid", fifo_if.fifo_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
